// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//
// Conditions three bouncing, active-low push-buttons (pause, speed-up,
// speed-down) for the downstream Control block. Each button gets its own
// identical channel. A channel synchronises the raw input, accepts a level
// change only after DB_CNT consecutive stable samples, and produces a
// one-cycle pulse for every accepted press.
//
// Parameters
//   DB_CNT        : consecutive stable synchronised samples needed to accept
//                   a level change (legal range 2 .. 2**20)
//
// Ports
//   clk           : in  system clock, all state changes on its rising edge
//   rst_n         : in  synchronous active-low reset
//   btn_p_raw     : in  raw pause button, active-low, asynchronous, bouncing
//   btn_spdup_raw : in  raw speed-up button, active-low, asynchronous
//   btn_spddn_raw : in  raw speed-down button, active-low, asynchronous
//   btn_p         : out debounced pause level, active-low
//   btn_spdup     : out debounced speed-up level, active-low
//   btn_spddn     : out debounced speed-down level, active-low
//   press_p       : out one-cycle pulse per accepted pause press
//   press_spdup   : out one-cycle pulse per accepted speed-up press
//   press_spddn   : out one-cycle pulse per accepted speed-down press
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// btn_conditioner_chan
//
// One debounce channel.
//
// Ports
//   clk     : in  system clock
//   rst_n   : in  synchronous active-low reset
//   raw_i   : in  raw active-low button, asynchronous to clk
//   level_o : out debounced active-low level (registered)
//   press_o : out one-cycle active-high pulse on an accepted press
//                 (registered)
//
// Timing: if edge k is the first edge at which the first synchroniser flop
// captures a low that stays low, the FSM sees that low at edge k+2 and then
// needs DB_CNT further low samples, so HELD is entered at edge k+DB_CNT+2.
// Release behaves the same way with the polarity inverted.
// ---------------------------------------------------------------------------
module btn_conditioner_chan #(
  parameter int DB_CNT = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  // The counter only ever needs to reach DB_CNT-1, so clog2(DB_CNT) bits
  // are enough. The guard keeps the width legal for degenerate values.
  localparam int CntW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic            sync1_q;
  logic            sync2_q;
  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            press_q;

  logic            cntAtMax;
  logic [CntW-1:0] cnt_d;

  // Terminal-count detect and the incremented count. The FSM only uses the
  // increment while below the terminal count, so the counter cannot wrap.
  assign cntAtMax = (cnt_q == CntMax);
  assign cnt_d    = cntAtMax ? cnt_q : (cnt_q + CntW'(1));

  // Two-flop synchroniser. Reset parks both flops at the released level so
  // the FSM never sees a spurious low straight after reset; a button still
  // held at that point is then picked up as a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM with registered level and pulse. The wait states count
  // consecutive samples at the new level; a single sample back at the old
  // level returns to the stable state and the whole wait starts over. The
  // counter is cleared on every state entry. The pulse is only raised on the
  // PRESS_WAIT -> HELD transition, so holding a button forever still gives
  // exactly one pulse and a release never gives one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!sync2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (sync2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cntAtMax) begin
            state_q <= HELD;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        HELD: begin
          if (sync2_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (!sync2_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cntAtMax) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b1;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// ---------------------------------------------------------------------------
// Top level: three independent channels, no interaction between them.
// ---------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DB_CNT = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_p_raw,
  input  logic btn_spdup_raw,
  input  logic btn_spddn_raw,
  output logic btn_p,
  output logic btn_spdup,
  output logic btn_spddn,
  output logic press_p,
  output logic press_spdup,
  output logic press_spddn
);

  // Pause button channel.
  btn_conditioner_chan #(
    .DB_CNT (DB_CNT)
  ) u_chanPause (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (btn_p_raw),
    .level_o (btn_p),
    .press_o (press_p)
  );

  // Speed-up button channel.
  btn_conditioner_chan #(
    .DB_CNT (DB_CNT)
  ) u_chanSpeedUp (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (btn_spdup_raw),
    .level_o (btn_spdup),
    .press_o (press_spdup)
  );

  // Speed-down button channel.
  btn_conditioner_chan #(
    .DB_CNT (DB_CNT)
  ) u_chanSpeedDown (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (btn_spddn_raw),
    .level_o (btn_spddn),
    .press_o (press_spddn)
  );

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//
// Drives the three raw buttons through directed scenarios and a random
// bouncing phase. A reference model predicts the outputs after every edge:
// the FSM-side sample is the raw value from two edges earlier, and a level
// flips once the sample has differed from the current level for DB_CNT+1
// consecutive edges. A press pulse follows every flip to the low level.
// Raw vector bit 0 = pause, bit 1 = speed-up, bit 2 = speed-down.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int DbCnt = 250;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_p_raw;
  logic btn_spdup_raw;
  logic btn_spddn_raw;
  logic btn_p;
  logic btn_spdup;
  logic btn_spddn;
  logic press_p;
  logic press_spdup;
  logic press_spddn;

  int checks = 0;
  int errors = 0;
  int edgeNum = 0;

  logic [2:0] mLevel;
  logic [2:0] mPulse;
  int         mRun [3];
  logic [2:0] mPipe [$];

  int pulseCnt [3];
  int pulseEdge [3];
  int lowCnt [3];

  btn_conditioner #(
    .DB_CNT (DbCnt)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_p_raw     (btn_p_raw),
    .btn_spdup_raw (btn_spdup_raw),
    .btn_spddn_raw (btn_spddn_raw),
    .btn_p         (btn_p),
    .btn_spdup     (btn_spdup),
    .btn_spddn     (btn_spddn),
    .press_p       (press_p),
    .press_spdup   (press_spdup),
    .press_spddn   (press_spddn)
  );

  // 20 ns clock period.
  always #10 clk = ~clk;

  // Reference model update for one rising edge.
  task automatic modelStep(input logic [2:0] raw, input logic rstn);
    logic [2:0] seen;
    if (!rstn) begin
      mPipe.delete();
      mPipe.push_back(3'b111);
      mPipe.push_back(3'b111);
      mLevel = 3'b111;
      mPulse = 3'b000;
      for (int c = 0; c < 3; c++) mRun[c] = 0;
    end else begin
      seen = mPipe.pop_front();
      mPipe.push_back(raw);
      for (int c = 0; c < 3; c++) begin
        mPulse[c] = 1'b0;
        if (seen[c] != mLevel[c]) mRun[c] = mRun[c] + 1;
        else mRun[c] = 0;
        if (mRun[c] == DbCnt + 1) begin
          mLevel[c] = seen[c];
          mRun[c]   = 0;
          mPulse[c] = ~seen[c];
        end
      end
    end
  endtask

  // One comparison: counts it and reports a failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h (edge %0d)",
             tag, observed, expected, edgeNum);
    end
  endtask

  // Compare every output against the model and update the event counters.
  task automatic compareModel();
    checkOutput("btn_p",       32'(btn_p),       32'(mLevel[0]));
    checkOutput("btn_spdup",   32'(btn_spdup),   32'(mLevel[1]));
    checkOutput("btn_spddn",   32'(btn_spddn),   32'(mLevel[2]));
    checkOutput("press_p",     32'(press_p),     32'(mPulse[0]));
    checkOutput("press_spdup", 32'(press_spdup), 32'(mPulse[1]));
    checkOutput("press_spddn", 32'(press_spddn), 32'(mPulse[2]));
    if (press_p === 1'b1)     begin pulseCnt[0]++; pulseEdge[0] = edgeNum; end
    if (press_spdup === 1'b1) begin pulseCnt[1]++; pulseEdge[1] = edgeNum; end
    if (press_spddn === 1'b1) begin pulseCnt[2]++; pulseEdge[2] = edgeNum; end
    if (btn_p === 1'b0)     lowCnt[0]++;
    if (btn_spdup === 1'b0) lowCnt[1]++;
    if (btn_spddn === 1'b0) lowCnt[2]++;
  endtask

  task automatic clearCounters();
    for (int c = 0; c < 3; c++) begin
      pulseCnt[c]  = 0;
      pulseEdge[c] = -1;
      lowCnt[c]    = 0;
    end
  endtask

  // Hold the given inputs for n edges, checking after each edge.
  task automatic applyStimulus(input logic [2:0] raw, input logic rstn,
                               input int n);
    for (int i = 0; i < n; i++) begin
      btn_p_raw     = raw[0];
      btn_spdup_raw = raw[1];
      btn_spddn_raw = raw[2];
      rst_n         = rstn;
      @(posedge clk);
      edgeNum++;
      modelStep(raw, rstn);
      #1;
      compareModel();
    end
  endtask

  initial begin
    int k;
    logic [2:0] cur;
    int len;

    btn_p_raw     = 1'b1;
    btn_spdup_raw = 1'b1;
    btn_spddn_raw = 1'b1;
    rst_n         = 1'b0;
    clearCounters();

    // Reset for one edge, then idle for 1000 cycles.
    applyStimulus(3'b111, 1'b0, 1);
    checkOutput("reset_levels", 32'({btn_spddn, btn_spdup, btn_p}), 32'h7);
    checkOutput("reset_pulses", 32'({press_spddn, press_spdup, press_p}), 32'h0);
    applyStimulus(3'b111, 1'b1, 1000);
    checkOutput("idle_pulses", 32'(pulseCnt[0] + pulseCnt[1] + pulseCnt[2]), 0);

    // Pause pressed for 500 cycles.
    clearCounters();
    k = edgeNum + 1;
    applyStimulus(3'b110, 1'b1, 500);
    applyStimulus(3'b111, 1'b1, 300);
    checkOutput("p_pulse_cnt",  32'(pulseCnt[0]), 1);
    checkOutput("p_latency",    32'(pulseEdge[0]), 32'(k + DbCnt + 2));
    checkOutput("p_low_cycles", 32'(lowCnt[0]), 500);
    checkOutput("p_others",     32'(pulseCnt[1] + pulseCnt[2] + lowCnt[1] + lowCnt[2]), 0);

    // Speed-up glitches that must be rejected, then a real press.
    clearCounters();
    applyStimulus(3'b101, 1'b1, 100);
    applyStimulus(3'b111, 1'b1, 10);
    applyStimulus(3'b101, 1'b1, 100);
    applyStimulus(3'b111, 1'b1, 300);
    checkOutput("spdup_glitch_pulse", 32'(pulseCnt[1]), 0);
    checkOutput("spdup_glitch_low",   32'(lowCnt[1]), 0);
    applyStimulus(3'b101, 1'b1, 300);
    applyStimulus(3'b111, 1'b1, 300);
    checkOutput("spdup_press_pulse", 32'(pulseCnt[1]), 1);

    // Speed-up and speed-down fall on the same edge.
    clearCounters();
    k = edgeNum + 1;
    applyStimulus(3'b001, 1'b1, 300);
    applyStimulus(3'b111, 1'b1, 300);
    checkOutput("simul_same_edge", 32'(pulseEdge[1]), 32'(pulseEdge[2]));
    checkOutput("simul_latency",   32'(pulseEdge[2]), 32'(k + DbCnt + 2));

    // Reset while speed-down is held; the press is re-detected afterwards.
    clearCounters();
    applyStimulus(3'b011, 1'b1, 300);
    applyStimulus(3'b011, 1'b0, 1);
    checkOutput("rst_held_level", 32'(btn_spddn), 1);
    checkOutput("rst_held_pulse", 32'(press_spddn), 0);
    k = edgeNum + 1;
    applyStimulus(3'b011, 1'b1, 300);
    applyStimulus(3'b111, 1'b1, 300);
    checkOutput("rst_redetect_cnt", 32'(pulseCnt[2]), 2);
    checkOutput("rst_redetect_lat", 32'(pulseEdge[2]), 32'(k + DbCnt + 2));

    // Long hold with a short high glitch: still a single pulse.
    clearCounters();
    applyStimulus(3'b110, 1'b1, 2000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b111, 1'b1, 1);
      checkOutput("hold_glitch_level", 32'(btn_p), 0);
    end
    applyStimulus(3'b110, 1'b1, 300);
    applyStimulus(3'b111, 1'b1, 300);
    checkOutput("hold_single_pulse", 32'(pulseCnt[0]), 1);

    // Random bouncing on all channels with occasional resets.
    cur = 3'b111;
    for (int seg = 0; seg < 60; seg++) begin
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 1) == 1) cur[c] = ~cur[c];
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 8);
      else len = $urandom_range(100, 400);
      if ($urandom_range(0, 19) == 0) applyStimulus(cur, 1'b0, 1);
      applyStimulus(cur, 1'b1, len);
    end
    applyStimulus(3'b111, 1'b1, 300);
    checkOutput("final_levels", 32'({btn_spddn, btn_spdup, btn_p}), 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CNT, default 250, giving the number of consecutive stable synchronized samples required to accept a level change; legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port btn_p_raw, input, 1 bit: raw pause push-button, active-low (1 = released), asynchronous to clk and bouncing.
REQ-005 The block SHALL have port btn_spdup_raw, input, 1 bit: raw speed-up push-button, active-low, asynchronous to clk and bouncing.
REQ-006 The block SHALL have port btn_spddn_raw, input, 1 bit: raw speed-down push-button, active-low, asynchronous to clk and bouncing.
REQ-007 The block SHALL have ports btn_p, btn_spdup and btn_spddn, output, 1 bit each: debounced active-low levels, drop-in replacements for the button inputs of the downstream Control block.
REQ-008 The block SHALL have ports press_p, press_spdup and press_spddn, output, 1 bit each: single-cycle active-high pulses, one per accepted press.

Function
REQ-009 Each of the three channels SHALL be an identical, independent instance of the logic in REQ-010..REQ-017, with no cross-channel priority or interaction.
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 Each channel SHALL implement a 4-state FSM with states IDLE (released), PRESS_WAIT, HELD and RELEASE_WAIT, plus a counter of width clog2(DB_CNT).
REQ-012 In IDLE, s2 == 0 SHALL cause a move to PRESS_WAIT with cnt = 0; otherwise the FSM SHALL stay in IDLE.
REQ-013 In PRESS_WAIT: s2 == 1 SHALL cause a return to IDLE with no output change (bounce rejected); s2 == 0 with cnt < DB_CNT-1 SHALL increment cnt; s2 == 0 with cnt == DB_CNT-1 SHALL cause a move to HELD.
REQ-014 On entering HELD, the debounced level SHALL go to 0 and the press pulse SHALL be 1 for exactly one clock cycle.
REQ-015 HELD and RELEASE_WAIT SHALL mirror REQ-012 and REQ-013 with the polarity of s2 inverted; on returning to IDLE the level SHALL go to 1, and no pulse SHALL be generated on release.
REQ-016 Latency: if edge k is the first edge at which s1 samples a low that stays low, HELD SHALL be entered at edge k+DB_CNT+2, and the level and pulse SHALL change immediately after that edge; release latency SHALL be identical.
REQ-017 The counter SHALL never wrap: it saturates at DB_CNT-1 and is cleared on every state entry.
REQ-018 A held button SHALL produce exactly one pulse regardless of hold duration; there is no auto-repeat.
REQ-019 Simultaneous presses on several channels SHALL produce pulses on the same cycle if their raw edges are sampled on the same edge.
REQ-020 Outputs SHALL be registered, with no combinational path from any raw input to any output.

Reset
REQ-021 While rst_n == 0 at a rising edge: s1 and s2 SHALL be set to 1, the FSM to IDLE, cnt to 0, btn_p, btn_spdup and btn_spddn to 1, and all press pulses to 0.
REQ-022 Reset asserted mid-operation (any state) SHALL take effect at the next edge and SHALL override all other transitions.
REQ-023 A button still physically held when reset is released SHALL be re-detected as a new press after the REQ-016 latency.

Verification (DB_CNT = 250, clk period 20 ns)
REQ-024 rst_n low for 1 edge, all raw inputs 1 -> all levels 1, all pulses 0, held for 1000 cycles.
REQ-025 btn_p_raw low for 10 us (500 cycles) -> btn_p low starting 252 edges after the first low sample, for 500 cycles; press_p high for exactly 1 cycle; other channels unchanged.
REQ-026 btn_spdup_raw glitches low for 100 cycles, high for 10 cycles, low for 100 cycles -> no pulse and btn_spdup stays 1; then low for 300 cycles -> exactly one pulse.
REQ-027 btn_spdup_raw and btn_spddn_raw fall on the same edge -> press_spdup and press_spddn assert on the same cycle.
REQ-028 rst_n pulsed low for 1 edge while btn_spddn is in HELD with the raw input still low -> btn_spddn returns to 1 after that edge, then a second press_spddn pulse appears 252 edges after reset is released.
REQ-029 A press held for 2000 cycles followed by a 3-cycle high glitch -> still exactly one pulse, and btn_p stays 0 throughout the glitch.
